// File: rtl/nib_track_writeback.sv
// nib_track_writeback
//   Writes the cached NIB track (SECTORS x 512 bytes) back to the SD image
//   through the hps_io sd_wr / sd_buff_din path. It also tracks whether the
//   floppy controller has modified track RAM since the track was loaded.
//
//   Optional feature: define WB_AUTOFLUSH_EN to start a writeback on its own
//   after IDLE_CYC quiet cycles with the track dirty.
//
// Ports
//   clk_sys, reset_n           clock, async active-low reset
//   cur_track[5:0]             track held in track RAM
//   disk_we                    controller write strobe (marks dirty)
//   flush_req                  one-cycle writeback request
//   img_mounted                mount pulse (discards dirty, aborts writeback)
//   img_present, img_readonly  image status
//   busy, dirty, wb_done       status outputs
//   sd_lba[31:0], sd_wr        SD sector write request
//   sd_ack, sd_buff_addr[8:0]  hps_io sector handshake and byte index
//   sd_buff_din[7:0]           byte returned to hps_io
//   tram_addr[12:0], tram_dout track RAM read port (1-cycle latency)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no writeback; flush requests evaluated here
// ARM   | sd_wr high, waiting for hps_io to start the sector (ack rise)
// XFER  | sector transfer in progress, waiting for ack fall
// ABORT | image remounted mid-writeback, waiting for ack to drop
module nib_track_writeback #(
  parameter int SECTORS  = 13,
  parameter int IDLE_CYC = 14318180
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [5:0]  cur_track,
  input  logic        disk_we,
  input  logic        flush_req,
  input  logic        img_mounted,
  input  logic        img_present,
  input  logic        img_readonly,
  output logic        busy,
  output logic        dirty,
  output logic        wb_done,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_din,
  output logic [12:0] tram_addr,
  input  logic [7:0]  tram_dout
);

  typedef enum logic [1:0] {IDLE, ARM, XFER, ABORT} state_t;

  localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

  state_t      state, state_nx;
  logic [3:0]  sec, sec_nx;
  logic [31:0] lba_nx;
  logic [31:0] lba_base;
  logic        wr_nx, busy_nx, done_nx, dirty_nx;
  logic        ack_s, ack_p;
  logic        ack_rise, ack_fall;
  logic        auto_flush;
  logic        flush_go;

  // sd_ack comes from another clock domain inside hps_io; edges are taken
  // on the registered copy.
  assign ack_rise = ack_s & ~ack_p;
  assign ack_fall = ~ack_s & ack_p;
  assign lba_base = 32'(SECTORS) * {26'd0, cur_track};
  assign flush_go = flush_req | auto_flush;

`ifdef WB_AUTOFLUSH_EN
  logic [23:0] idle_cnt;

  assign auto_flush = (state == IDLE) && dirty && (idle_cnt == 24'(IDLE_CYC - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      idle_cnt <= '0;
    else if (disk_we || auto_flush)
      idle_cnt <= '0;
    else if (state == IDLE && dirty)
      idle_cnt <= idle_cnt + 24'd1;
  end
`else
  logic unused_idle_cyc;
  assign unused_idle_cyc = (IDLE_CYC != 0);
  assign auto_flush      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    sec_nx   = sec;
    lba_nx   = sd_lba;
    wr_nx    = sd_wr;
    busy_nx  = busy;
    done_nx  = 1'b0;
    dirty_nx = dirty;
    if (img_mounted)
      dirty_nx = 1'b0;
    case (state)
      IDLE: begin
        if (flush_go) begin
          if (dirty && img_present && !img_readonly) begin
            // Every sector is captured from here on, so the track counts as
            // clean unless the controller writes again.
            state_nx = ARM;
            sec_nx   = 4'd0;
            lba_nx   = lba_base;
            wr_nx    = 1'b1;
            busy_nx  = 1'b1;
            dirty_nx = 1'b0;
          end else begin
            done_nx = 1'b1;
            // A write-protected image can never take the data: drop it.
            if (dirty && img_readonly)
              dirty_nx = 1'b0;
          end
        end
      end
      ARM: begin
        if (img_mounted) begin
          state_nx = ABORT;
          wr_nx    = 1'b0;
        end else if (ack_rise) begin
          state_nx = XFER;
          // Release sd_wr early on the last sector so hps_io stops after it.
          if (sec == LAST_SEC)
            wr_nx = 1'b0;
        end
      end
      XFER: begin
        if (img_mounted) begin
          state_nx = ABORT;
          wr_nx    = 1'b0;
        end else if (ack_fall) begin
          if (sd_wr) begin
            state_nx = ARM;
            sec_nx   = sec + 4'd1;
            lba_nx   = sd_lba + 32'd1;
          end else begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end
        end
      end
      ABORT: begin
        wr_nx = 1'b0;
        if (!ack_s) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (disk_we)
      dirty_nx = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sec         <= 4'd0;
      sd_lba      <= 32'd0;
      sd_wr       <= 1'b0;
      busy        <= 1'b0;
      wb_done     <= 1'b0;
      dirty       <= 1'b0;
      ack_s       <= 1'b0;
      ack_p       <= 1'b0;
      tram_addr   <= 13'd0;
      sd_buff_din <= 8'd0;
    end else begin
      state       <= state_nx;
      sec         <= sec_nx;
      sd_lba      <= lba_nx;
      sd_wr       <= wr_nx;
      busy        <= busy_nx;
      wb_done     <= done_nx;
      dirty       <= dirty_nx;
      ack_s       <= sd_ack;
      ack_p       <= ack_s;
      tram_addr   <= {sec, sd_buff_addr};
      sd_buff_din <= tram_dout;
    end
  end

endmodule

// File: tb/tb_nib_track_writeback.sv
// tb_nib_track_writeback
//   Directed bench for nib_track_writeback: a behavioural track RAM and a
//   simple hps_io sector responder, with hand-computed expected values.
//   Build with WB_AUTOFLUSH_EN defined to exercise the auto-flush timer.
module tb_nib_track_writeback;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  cur_track = '0;
  logic        disk_we = 1'b0;
  logic        flush_req = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_present = 1'b1;
  logic        img_readonly = 1'b0;
  logic        busy, dirty, wb_done, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_din;
  logic [12:0] tram_addr;
  logic [7:0]  tram_dout = '0;

  logic [7:0]  tram_mem [0:8191];

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_wr = 0;
  logic wr_prev = 1'b0;
  int lba_err = 0;
  int byte_err = 0;

  nib_track_writeback #(.SECTORS(13), .IDLE_CYC(1000)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .cur_track    (cur_track),
    .disk_we      (disk_we),
    .flush_req    (flush_req),
    .img_mounted  (img_mounted),
    .img_present  (img_present),
    .img_readonly (img_readonly),
    .busy         (busy),
    .dirty        (dirty),
    .wb_done      (wb_done),
    .sd_lba       (sd_lba),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_din  (sd_buff_din),
    .tram_addr    (tram_addr),
    .tram_dout    (tram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) tram_dout <= tram_mem[tram_addr];

  always @(negedge clk_sys) begin
    if (wb_done) n_done++;
    if (sd_wr && !wr_prev) n_wr++;
    wr_prev = sd_wr;
  end

  function automatic logic [7:0] tpat(input int i);
    return 8'((i * 37) + (i >> 9) * 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic pulse_we();
    disk_we = 1'b1; tick(1); disk_we = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1; tick(1); flush_req = 1'b0;
  endtask

  // One sector as hps_io would run it; sd_wr is already high on entry.
  task automatic serve_sector(input int exp_lba, input bit walk, input int s, input bit we_mid);
    if (sd_lba != 32'(exp_lba)) lba_err++;
    sd_ack = 1'b1;
    if (walk) begin
      for (int k = 0; k < 512; k++) begin
        sd_buff_addr = 9'(k);
        tick(3);
        if (sd_buff_din !== tpat(s * 512 + k)) byte_err++;
      end
    end else begin
      tick(6);
      if (we_mid) pulse_we();
    end
    sd_ack = 1'b0;
    tick(5);
  endtask

  task automatic run_writeback(input bit walk, input int base, input int we_sec, output int nsec);
    int t;
    nsec = 0;
    for (int i = 0; i < 20; i++) begin
      t = 0;
      while (!sd_wr && busy && t < 50) begin tick(1); t++; end
      if (!busy) break;
      if (!sd_wr) begin
        chk("wait_sd_wr", 32'(sd_wr), 32'd1);
        break;
      end
      serve_sector(base + i, walk, i, i == we_sec);
      nsec++;
    end
    t = 0;
    while (busy && t < 50) begin tick(1); t++; end
  endtask

  initial begin
    int n, t, d0, w0;
    for (int i = 0; i < 8192; i++) tram_mem[i] = tpat(i);

    // reset values
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dirty", 32'(dirty), 0);
    chk("rst_wb_done", 32'(wb_done), 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_sd_buff_din", 32'(sd_buff_din), 0);
    chk("rst_tram_addr", 32'(tram_addr), 0);
    reset_n = 1'b1;
    tick(2);

    // 1: full writeback of track 5 with byte checks
    for (int i = 0; i < 10; i++) begin pulse_we(); tick(1); end
    chk("t1_dirty_set", 32'(dirty), 1);
    cur_track = 6'd5;
    d0 = n_done; w0 = n_wr; lba_err = 0; byte_err = 0;
    pulse_flush();
    chk("t1_sd_wr", 32'(sd_wr), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_dirty_clr", 32'(dirty), 0);
    chk("t1_lba0", sd_lba, 65);
    run_writeback(1'b1, 65, -1, n);
    tick(3);
    chk("t1_sectors", 32'(n), 13);
    chk("t1_lba_err", 32'(lba_err), 0);
    chk("t1_byte_err", 32'(byte_err), 0);
    chk("t1_done_cnt", 32'(n_done - d0), 1);
    chk("t1_wr_rises", 32'(n_wr - w0), 1);
    chk("t1_dirty_end", 32'(dirty), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // 2: flush while clean
    d0 = n_done; w0 = n_wr;
    pulse_flush();
    chk("t2_wb_done", 32'(wb_done), 1);
    chk("t2_busy", 32'(busy), 0);
    tick(1);
    chk("t2_wb_done_1cyc", 32'(wb_done), 0);
    tick(20);
    chk("t2_no_sd_wr", 32'(n_wr - w0), 0);
    chk("t2_done_cnt", 32'(n_done - d0), 1);

    // 3: read-only image discards dirty track
    pulse_we(); tick(1);
    img_readonly = 1'b1;
    w0 = n_wr;
    pulse_flush();
    chk("t3_wb_done", 32'(wb_done), 1);
    chk("t3_dirty", 32'(dirty), 0);
    tick(10);
    chk("t3_no_sd_wr", 32'(n_wr - w0), 0);
    img_readonly = 1'b0;

    // 4: disk_we during sector 4 keeps track dirty, all sectors written
    pulse_we(); tick(1);
    cur_track = 6'd2;
    d0 = n_done; lba_err = 0;
    pulse_flush();
    run_writeback(1'b0, 26, 4, n);
    tick(3);
    chk("t4_sectors", 32'(n), 13);
    chk("t4_lba_err", 32'(lba_err), 0);
    chk("t4_done_cnt", 32'(n_done - d0), 1);
    chk("t4_dirty_after", 32'(dirty), 1);

    // 5: remount during sector 2
    cur_track = 6'd1;
    d0 = n_done; w0 = n_wr; lba_err = 0;
    pulse_flush();
    serve_sector(13, 1'b0, 0, 1'b0);
    serve_sector(14, 1'b0, 1, 1'b0);
    chk("t5_lba_err", 32'(lba_err), 0);
    chk("t5_sd_wr_s2", 32'(sd_wr), 1);
    sd_ack = 1'b1;
    tick(3);
    img_mounted = 1'b1; tick(1); img_mounted = 1'b0;
    chk("t5_sd_wr_drop", 32'(sd_wr), 0);
    chk("t5_busy_abort", 32'(busy), 1);
    tick(4);
    chk("t5_no_done_yet", 32'(n_done - d0), 0);
    sd_ack = 1'b0;
    t = 0;
    while (busy && t < 20) begin tick(1); t++; end
    tick(20);
    chk("t5_done_cnt", 32'(n_done - d0), 1);
    chk("t5_dirty", 32'(dirty), 0);
    chk("t5_no_rearm", 32'(n_wr - w0), 1);
    chk("t5_lba_hold", sd_lba, 15);

    // async reset in the middle of a sector
    pulse_we(); tick(1);
    cur_track = 6'd3;
    pulse_flush();
    sd_ack = 1'b1;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_sd_wr", 32'(sd_wr), 0);
    chk("rst_mid_dirty", 32'(dirty), 0);
    chk("rst_mid_lba", sd_lba, 0);
    sd_ack = 1'b0;
    reset_n = 1'b1;
    tick(3);

    // 6: auto-flush after IDLE_CYC quiet cycles
    cur_track = 6'd0;
    w0 = n_wr;
    disk_we = 1'b1; tick(1); disk_we = 1'b0;
`ifdef WB_AUTOFLUSH_EN
    t = 0;
    while (!sd_wr && t < 1200) begin tick(1); t++; end
    chk("t6_auto_delay_ok", 32'(t >= 998 && t <= 1002), 1);
    chk("t6_auto_lba", sd_lba, 0);
    run_writeback(1'b0, 0, -1, n);
    chk("t6_auto_sectors", 32'(n), 13);
`else
    tick(1100);
    chk("t6_no_auto_wr", 32'(n_wr - w0), 0);
    chk("t6_no_auto_busy", 32'(busy), 0);
    chk("t6_still_dirty", 32'(dirty), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
